// File: rtl/clock_sequencer.sv
// Drives the clock generator ENABLE: post-reset warm-up, then free-run, fixed-length burst or single step.
// All outputs are registered; STATE exposes the FSM for debug and checkers.
module clock_sequencer #(
  parameter int CNT_W  = 8,
  parameter int WARMUP = 4,
  parameter int CYC_W  = 16
) (
  input  logic             CLOCK,
  input  logic             nRESET,
  input  logic             RUN,
  input  logic             HALT,
  input  logic             STEP,
  input  logic             BURST_START,
  input  logic [CNT_W-1:0] BURST_LEN,
  output logic             ENABLE,
  output logic             BUSY,
  output logic             DONE,
  output logic             READY,
  output logic [2:0]       STATE,
  output logic [CYC_W-1:0] CYCLES
);

  typedef enum logic [2:0] {
    S_WARM  = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_BURST = 3'd3,
    S_STEP  = 3'd4
  } state_t;

  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic               enable_q, enable_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;
  logic               warm_last;

  // WARMUP of 0 or 1 both leave WARM on the first edge after release.
  assign warm_last = (WARMUP <= 1) || (warm_q == WARM_W'(WARMUP - 1));

  // Commands are single-cycle pulses (RUN is a level) sampled only in IDLE,
  // except RUN/HALT which are also watched in RUN and HALT in BURST.
  // Nothing is queued: a pulse not acted on in its sampling cycle is lost.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    warm_d   = warm_q;
    done_d   = 1'b0;
    ready_d  = ready_q;
    cycles_d = cycles_q;

    if (enable_q && (cycles_q != {CYC_W{1'b1}})) begin
      cycles_d = cycles_q + 1'b1;
    end

    case (state_q)
      S_WARM: begin
        if (warm_last) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (HALT) begin
          state_d = S_IDLE;
        end else if (STEP) begin
          state_d = S_STEP;
        end else if (BURST_START) begin
          if (BURST_LEN == '0) begin
            // Zero-length burst completes at once; merged if a DONE is already showing.
            done_d = ~done_q;
          end else begin
            state_d = S_BURST;
            cnt_d   = BURST_LEN;
          end
        end else if (RUN) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!RUN || HALT) begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (HALT) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_WARM;
      end
    endcase

    enable_d = (state_d == S_RUN) || (state_d == S_BURST) || (state_d == S_STEP);
  end

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= S_WARM;
      cnt_q    <= '0;
      warm_q   <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      warm_q   <= warm_d;
      enable_q <= enable_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      cycles_q <= cycles_d;
    end
  end

  assign ENABLE = enable_q;
  assign BUSY   = enable_q;
  assign DONE   = done_q;
  assign READY  = ready_q;
  assign STATE  = state_q;
  assign CYCLES = cycles_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Bench for clock_sequencer: directed vector table, hand-written corner sequences,
// and randomized commands checked against a behavioural model.
module tb_clock_sequencer;

  localparam int CNT_W  = 8;
  localparam int WARMUP = 4;
  localparam int CYC_W  = 16;
  localparam int unsigned CYC_MAX = (1 << CYC_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic             run_r, halt_r, step_r, bs_r;
  logic [CNT_W-1:0] len_r;

  logic             enable, busy, done, ready;
  logic [2:0]       state;
  logic [CYC_W-1:0] cycles;

  logic             enable2, busy2, done2, ready2;
  logic [2:0]       state2;
  logic [3:0]       cycles2;

  clock_sequencer #(.CNT_W(CNT_W), .WARMUP(WARMUP), .CYC_W(CYC_W)) dut (
    .CLOCK(clk), .nRESET(nrst), .RUN(run_r), .HALT(halt_r), .STEP(step_r),
    .BURST_START(bs_r), .BURST_LEN(len_r),
    .ENABLE(enable), .BUSY(busy), .DONE(done), .READY(ready), .STATE(state), .CYCLES(cycles)
  );

  // Second instance: no warm-up and a narrow saturating cycle counter.
  clock_sequencer #(.CNT_W(CNT_W), .WARMUP(0), .CYC_W(4)) dut_small (
    .CLOCK(clk), .nRESET(nrst), .RUN(run_r), .HALT(halt_r), .STEP(step_r),
    .BURST_START(bs_r), .BURST_LEN(len_r),
    .ENABLE(enable2), .BUSY(busy2), .DONE(done2), .READY(ready2), .STATE(state2), .CYCLES(cycles2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_in(input bit run, input bit halt, input bit step, input bit bs, input int len);
    run_r  = run;
    halt_r = halt;
    step_r = step;
    bs_r   = bs;
    len_r  = CNT_W'(len);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  // behavioural model
  int          m_edges;
  bit          m_ready, m_run, m_step, m_done, m_en;
  int          m_rem;
  int unsigned m_cyc;
  int          m_state;

  task automatic model_reset();
    m_edges = 0; m_ready = 0; m_run = 0; m_step = 0; m_done = 0; m_en = 0;
    m_rem = 0; m_cyc = 0; m_state = 0;
  endtask

  task automatic model_edge(input bit run, input bit halt, input bit step, input bit bs, input int len);
    bit prev_done;
    prev_done = m_done;
    if (m_en && m_cyc < CYC_MAX) m_cyc++;
    m_done = 0;
    if (!m_ready) begin
      m_edges++;
      if (m_edges >= ((WARMUP > 0) ? WARMUP : 1)) m_ready = 1;
    end else if (m_run) begin
      if (!run || halt) m_run = 0;
    end else if (m_rem > 0) begin
      if (halt && !m_step) begin
        m_rem = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end
    end else if (!halt) begin
      if (step) begin
        m_rem = 1; m_step = 1;
      end else if (bs) begin
        if (len == 0) m_done = !prev_done;
        else begin m_rem = len; m_step = 0; end
      end else if (run) begin
        m_run = 1;
      end
    end
    m_en = m_run || (m_rem > 0);
    m_state = !m_ready ? 0 : m_run ? 2 : (m_rem > 0) ? (m_step ? 4 : 3) : 1;
  endtask

  task automatic check_model(input int c);
    check($sformatf("rnd%0d_enable", c), enable, m_en);
    check($sformatf("rnd%0d_busy", c),   busy,   m_en);
    check($sformatf("rnd%0d_done", c),   done,   m_done);
    check($sformatf("rnd%0d_ready", c),  ready,  m_ready);
    check($sformatf("rnd%0d_state", c),  state,  m_state);
    check($sformatf("rnd%0d_cycles", c), cycles, m_cyc);
  endtask

  // vector table
  typedef struct {
    bit run, halt, step, bs;
    int len;
    bit en, done, rdy;
    int st;
    int cyc;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(bit run, bit halt, bit step, bit bs, int len,
                              bit en, bit dn, bit rdy, int st, int cyc);
    vec_t v;
    v.run = run; v.halt = halt; v.step = step; v.bs = bs; v.len = len;
    v.en = en; v.done = dn; v.rdy = rdy; v.st = st; v.cyc = cyc;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //             run hlt stp bs len   en dn rdy st cyc
    vecs[0]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 1, 1, 3,   0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0,   0, 0, 1, 1, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 2, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0,   1, 0, 1, 2, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0,   0, 0, 1, 1, 2);
    vecs[7]  = mk(0, 0, 0, 1, 3,   1, 0, 1, 3, 2);
    vecs[8]  = mk(0, 0, 0, 0, 0,   1, 0, 1, 3, 3);
    vecs[9]  = mk(1, 0, 1, 1, 9,   1, 0, 1, 3, 4);
    vecs[10] = mk(0, 0, 0, 0, 0,   0, 1, 1, 1, 5);
    vecs[11] = mk(0, 0, 0, 0, 0,   0, 0, 1, 1, 5);
    vecs[12] = mk(0, 0, 0, 1, 0,   0, 1, 1, 1, 5);
    vecs[13] = mk(0, 0, 0, 0, 0,   0, 0, 1, 1, 5);
    vecs[14] = mk(0, 0, 1, 1, 5,   1, 0, 1, 4, 5);
    vecs[15] = mk(0, 0, 0, 0, 0,   0, 1, 1, 1, 6);
    vecs[16] = mk(0, 0, 1, 0, 0,   1, 0, 1, 4, 6);
    vecs[17] = mk(0, 0, 1, 0, 0,   0, 1, 1, 1, 7);
    vecs[18] = mk(0, 0, 1, 0, 0,   1, 0, 1, 4, 7);
    vecs[19] = mk(0, 0, 0, 0, 0,   0, 1, 1, 1, 8);
    vecs[20] = mk(1, 1, 0, 0, 0,   0, 0, 1, 1, 8);
    vecs[21] = mk(1, 0, 1, 0, 0,   1, 0, 1, 4, 8);
    vecs[22] = mk(1, 1, 0, 0, 0,   0, 1, 1, 1, 9);
    vecs[23] = mk(1, 0, 0, 0, 0,   1, 0, 1, 2, 9);
    vecs[24] = mk(1, 0, 1, 1, 2,   1, 0, 1, 2, 10);
    vecs[25] = mk(1, 1, 0, 0, 0,   0, 0, 1, 1, 11);

    set_in(0, 0, 0, 0, 0);
    nrst = 1'b0;
    #12;
    check("reset_enable", enable, 0);
    check("reset_busy",   busy,   0);
    check("reset_done",   done,   0);
    check("reset_ready",  ready,  0);
    check("reset_state",  state,  0);
    check("reset_cycles", cycles, 0);

    // directed vector table
    do_reset();
    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].run, vecs[i].halt, vecs[i].step, vecs[i].bs, vecs[i].len);
      tick();
      check($sformatf("vec%0d_enable", i), enable, vecs[i].en);
      check($sformatf("vec%0d_busy", i),   busy,   vecs[i].en);
      check($sformatf("vec%0d_done", i),   done,   vecs[i].done);
      check($sformatf("vec%0d_ready", i),  ready,  vecs[i].rdy);
      check($sformatf("vec%0d_state", i),  state,  vecs[i].st);
      check($sformatf("vec%0d_cycles", i), cycles, vecs[i].cyc);
    end

    // RUN held through warm-up for 20 enabled cycles; narrow instance saturates
    do_reset();
    set_in(1, 0, 0, 0, 0);
    for (int e = 1; e <= 24; e++) begin
      tick();
      if (e == 1) begin
        check("nowarm_ready_e1", ready2, 1);
        check("nowarm_state_e1", state2, 1);
        check("warm_ready_e1",   ready,  0);
      end
      if (e == 2) begin
        check("nowarm_state_e2",  state2,  2);
        check("nowarm_enable_e2", enable2, 1);
      end
      if (e == 3) check("warm_enable_e3", enable, 0);
      if (e == 4) begin
        check("warm_ready_e4",  ready,  1);
        check("warm_enable_e4", enable, 0);
      end
      if (e == 5) begin
        check("warm_enable_e5", enable, 1);
        check("warm_state_e5",  state,  2);
      end
      if (e == 10) check("nowarm_cycles_e10", cycles2, 8);
    end
    set_in(0, 0, 0, 0, 0);
    tick();
    check("run20_cycles", cycles,  20);
    check("run20_enable", enable,  0);
    check("run20_state",  state,   1);
    check("run20_done",   done,    0);
    check("sat_cycles",   cycles2, 15);

    // async reset in the middle of RUN
    set_in(1, 0, 0, 0, 0);
    tick();
    tick();
    check("prerst_enable", enable, 1);
    #2;
    nrst = 1'b0;
    #1;
    check("asyncrst_enable", enable, 0);
    check("asyncrst_state",  state,  0);
    check("asyncrst_cycles", cycles, 0);
    check("asyncrst_ready",  ready,  0);
    check("asyncrst_done",   done,   0);

    // reset mid-burst: no DONE afterwards
    do_reset();
    repeat (4) tick();
    set_in(0, 0, 0, 1, 5);
    tick();
    set_in(0, 0, 0, 0, 0);
    tick();
    #2;
    nrst = 1'b0;
    #3;
    nrst = 1'b1;
    begin
      int dn;
      dn = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        dn += int'(done);
      end
      check("burst_rst_done_count", dn, 0);
    end

    // BURST_LEN=10 aborted by HALT after 4 enabled cycles
    do_reset();
    repeat (4) tick();
    set_in(0, 0, 0, 1, 10);
    tick();
    set_in(0, 0, 0, 0, 0);
    repeat (3) tick();
    check("halt_pre_enable", enable, 1);
    set_in(0, 1, 0, 0, 0);
    tick();
    check("halt_enable", enable, 0);
    check("halt_state",  state,  1);
    check("halt_done",   done,   0);
    check("halt_cycles", cycles, 4);
    set_in(0, 0, 0, 0, 0);
    begin
      int dn;
      dn = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        dn += int'(done);
      end
      check("halt_done_count", dn, 0);
      check("halt_cycles_after", cycles, 4);
    end

    // three back-to-back steps
    do_reset();
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 1, 0, 0);
      tick();
      check($sformatf("step%0d_enable", k), enable, 1);
      check($sformatf("step%0d_state", k),  state,  4);
      set_in(0, 0, 0, 0, 0);
      tick();
      check($sformatf("step%0d_done", k),     done,   1);
      check($sformatf("step%0d_enable_lo", k), enable, 0);
    end
    tick();
    check("step3_cycles", cycles, 3);
    check("step3_done_lo", done, 0);

    // randomized commands against the model
    do_reset();
    model_reset();
    begin
      bit run;
      run = 0;
      for (int c = 0; c < 3000; c++) begin
        bit halt, step, bs;
        int len;
        if ($urandom_range(0, 399) == 0) begin
          do_reset();
          model_reset();
          check_model(c);
        end else begin
          if ($urandom_range(0, 11) == 0) run = !run;
          halt = ($urandom_range(0, 19) == 0);
          step = ($urandom_range(0, 9) == 0);
          bs   = ($urandom_range(0, 7) == 0);
          len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 5));
          set_in(run, halt, step, bs, len);
          tick();
          model_edge(run, halt, step, bs, len);
          check_model(c);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
